// File: rtl/io_uart_fifo.sv
// Memory-mapped UART buffer: TX FIFO drained to the uart core by a small FSM, RX FIFO read by the CPU.
// Optional loopback path (register 0x010) is compiled in with `define IO_UART_LOOPBACK_EN.
module io_uart_fifo #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        io_read_valid_i,
    input  logic        io_write_valid_i,
    input  logic [11:0] io_addr_i,
    input  logic [31:0] io_wdata_i,
    output logic [31:0] io_rdata_o,
    output logic [7:0]  uart_tx_data_o,
    output logic        uart_tx_strobe_o,
    input  logic        uart_tx_busy_i,
    input  logic [7:0]  uart_rx_data_i,
    input  logic        uart_rx_valid_i,
    output logic        uart_rx_ready_o
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;

    localparam logic [11:0] ADDR_DATA = 12'h000;
    localparam logic [11:0] ADDR_RX   = 12'h008;
    localparam logic [11:0] ADDR_CTRL = 12'h010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_WAIT
    } tx_state_t;

    tx_state_t        tx_state, tx_state_next;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_CW-1:0] tx_count;
    logic             tx_full, tx_empty, tx_wr_req, tx_push, tx_pop, tx_ovf, tx_ovf_set;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_CW-1:0] rx_count;
    logic             rx_full, rx_empty, rx_push, rx_pop, rx_ready;
    logic [7:0]       rx_push_data;
    logic [8:0]       rx_count_w;
    logic [7:0]       rx_count_sat;

    logic             status_rd, loopback;
    logic [31:0]      rdata_next;
    logic             unused_wdata;

    assign unused_wdata = ^io_wdata_i[31:8];

    // ---------------- TX FIFO ----------------
    assign tx_full    = (tx_count == TX_CW'(TX_DEPTH));
    assign tx_empty   = (tx_count == '0);
    assign tx_wr_req  = io_write_valid_i && (io_addr_i == ADDR_DATA);
    // A full FIFO still accepts a write when the drain frees a slot in the same cycle.
    assign tx_push    = tx_wr_req && (!tx_full || tx_pop);
    assign tx_ovf_set = tx_wr_req && tx_full && !tx_pop;
    assign status_rd  = io_read_valid_i && (io_addr_i == ADDR_DATA);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            tx_ovf    <= 1'b0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + TX_CW'(1);
                2'b01:   tx_count <= tx_count - TX_CW'(1);
                default: tx_count <= tx_count;
            endcase
            if (tx_ovf_set)     tx_ovf <= 1'b1;
            else if (status_rd) tx_ovf <= 1'b0;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers and counts define validity.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= io_wdata_i[7:0];
    end

    // ---------------- TX drain FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) tx_state <= ST_IDLE;
        else       tx_state <= tx_state_next;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tx_state_next = tx_state;
        tx_pop        = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                if (!tx_empty && !uart_tx_busy_i) begin
                    tx_pop        = 1'b1;
                    tx_state_next = ST_HOLD;
                end
            end
            ST_HOLD: tx_state_next = ST_WAIT;
            ST_WAIT: if (!uart_tx_busy_i) tx_state_next = ST_IDLE;
            default: tx_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            uart_tx_strobe_o <= 1'b0;
            uart_tx_data_o   <= 8'h00;
        end else begin
            uart_tx_strobe_o <= tx_pop;
            if (tx_pop) uart_tx_data_o <= tx_mem[tx_rd_ptr];
        end
    end

    // ---------------- RX FIFO ----------------
    assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
    assign rx_empty = (rx_count == '0);
    assign rx_ready = !rx_full && !loopback;
    assign uart_rx_ready_o = !rst_i && rx_ready;
    assign rx_pop   = io_read_valid_i && (io_addr_i == ADDR_RX) && !rx_empty;

`ifdef IO_UART_LOOPBACK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                             loopback <= 1'b0;
        else if (io_write_valid_i && (io_addr_i == ADDR_CTRL)) loopback <= io_wdata_i[0];
    end

    // Looped-back bytes are taken from the strobe itself and dropped when RX is full.
    assign rx_push      = loopback ? (uart_tx_strobe_o && !rx_full)
                                   : (uart_rx_valid_i && uart_rx_ready_o);
    assign rx_push_data = loopback ? uart_tx_data_o : uart_rx_data_i;
`else
    assign loopback     = 1'b0;
    assign rx_push      = uart_rx_valid_i && uart_rx_ready_o;
    assign rx_push_data = uart_rx_data_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + RX_CW'(1);
                2'b01:   rx_count <= rx_count - RX_CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_push_data;
    end

    // ---------------- Register read ----------------
    assign rx_count_w   = 9'(rx_count);
    assign rx_count_sat = rx_count_w[8] ? 8'hFF : rx_count_w[7:0];

    always_comb begin
        rdata_next = 32'h0;
        case (io_addr_i)
            ADDR_DATA: rdata_next = {16'h0, rx_count_sat, 5'h0, tx_ovf, !rx_empty, tx_full};
            ADDR_RX:   rdata_next = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd_ptr]};
`ifdef IO_UART_LOOPBACK_EN
            ADDR_CTRL: rdata_next = {31'h0, loopback};
`endif
            default:   rdata_next = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) io_rdata_o <= 32'h0;
        else       io_rdata_o <= rdata_next;
    end

endmodule

// File: tb/tb_io_uart_fifo.sv
// Self-checking bench for io_uart_fifo: uart busy model, strobe log and queue-based FIFO reference.
// Build with +define+IO_UART_LOOPBACK_EN to also exercise the loopback register.
module tb_io_uart_fifo;

    localparam int TX_DEPTH = 16;
    localparam int RX_DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        io_read_valid_i, io_write_valid_i;
    logic [11:0] io_addr_i;
    logic [31:0] io_wdata_i;
    logic [31:0] io_rdata_o;
    logic [7:0]  uart_tx_data_o;
    logic        uart_tx_strobe_o;
    logic        uart_tx_busy_i;
    logic [7:0]  uart_rx_data_i;
    logic        uart_rx_valid_i;
    logic        uart_rx_ready_o;

    io_uart_fifo #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .io_read_valid_i  (io_read_valid_i),
        .io_write_valid_i (io_write_valid_i),
        .io_addr_i        (io_addr_i),
        .io_wdata_i       (io_wdata_i),
        .io_rdata_o       (io_rdata_o),
        .uart_tx_data_o   (uart_tx_data_o),
        .uart_tx_strobe_o (uart_tx_strobe_o),
        .uart_tx_busy_i   (uart_tx_busy_i),
        .uart_rx_data_i   (uart_rx_data_i),
        .uart_rx_valid_i  (uart_rx_valid_i),
        .uart_rx_ready_o  (uart_rx_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    always @(posedge clk_i) cycle <= cycle + 1;

    // uart model: busy for 10 cycles after each strobe, or forced high by the bench
    typedef struct {
        logic [7:0] data;
        int         cyc;
        logic       busy;
    } strobe_t;

    strobe_t strobes[$];
    int      busy_cnt;
    logic    force_busy = 1'b0;

    assign uart_tx_busy_i = force_busy || (busy_cnt != 0);

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                 busy_cnt <= 0;
        else if (uart_tx_strobe_o) busy_cnt <= 10;
        else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 1;
    end

    always @(posedge clk_i) begin
        if (!rst_i && uart_tx_strobe_o)
            strobes.push_back('{data: uart_tx_data_o, cyc: cycle, busy: uart_tx_busy_i});
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bus helpers (stimulus only) ----------------
    task automatic io_write(input logic [11:0] addr, input logic [31:0] data);
        io_addr_i        = addr;
        io_wdata_i       = data;
        io_write_valid_i = 1'b1;
        @(negedge clk_i);
        io_write_valid_i = 1'b0;
    endtask

    task automatic io_read(input logic [11:0] addr, output logic [31:0] data);
        io_addr_i       = addr;
        io_read_valid_i = 1'b1;
        @(negedge clk_i);
        io_read_valid_i = 1'b0;
        data            = io_rdata_o;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        for (int i = 0; i < budget && strobes.size() < n; i++) @(negedge clk_i);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_tests++;
        if (uart_tx_strobe_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobe: got %b expected 0", uart_tx_strobe_o);
        end
        n_tests++;
        if (uart_rx_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_rx_ready: got %b expected 0", uart_rx_ready_o);
        end
        n_tests++;
        if (io_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", io_rdata_o);
        end
        rst_i = 1'b0;
        io_read(12'h000, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL reset_status: got %h expected 00000000", d);
        end
        n_tests++;
        if (uart_rx_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_rx_ready: got %b expected 1", uart_rx_ready_o);
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [31:0] d;
        strobes.delete();
        io_write(12'h000, 32'hA5);
        io_write(12'h000, 32'hB6);
        io_write(12'h000, 32'hC7);
        for (int i = 0; i < 20 && !uart_tx_strobe_o; i++) @(negedge clk_i);
        n_tests++;
        if (uart_tx_strobe_o !== 1'b1) begin
            n_fail++; $display("FAIL midreset_strobe_seen: got %b expected 1", uart_tx_strobe_o);
        end
        rst_i = 1'b1;
        #1;
        n_tests++;
        if (uart_tx_strobe_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset_truncate: got %b expected 0", uart_tx_strobe_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        strobes.delete();
        repeat (40) @(negedge clk_i);
        n_tests++;
        if (strobes.size() != 0) begin
            n_fail++; $display("FAIL midreset_fifo_discard: got %0d strobes expected 0", strobes.size());
        end
        io_read(12'h000, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL midreset_status: got %h expected 00000000", d);
        end
    endtask

    task automatic test_tx_order();
        logic [7:0] model[$];
        int n;
        logic [7:0] b;
        strobes.delete();
        io_write(12'h000, 32'h41);
        io_write(12'h000, 32'h42);
        io_write(12'h000, 32'h43);
        wait_strobes(3, 200);
        n_tests++;
        if (strobes.size() != 3) begin
            n_fail++; $display("FAIL tx_abc_count: got %0d expected 3", strobes.size());
        end
        for (int i = 0; i < strobes.size() && i < 3; i++) begin
            n_tests++;
            if (strobes[i].data !== 8'(8'h41 + i)) begin
                n_fail++; $display("FAIL tx_abc_data[%0d]: got %h expected %h", i, strobes[i].data, 8'(8'h41 + i));
            end
            n_tests++;
            if (strobes[i].busy !== 1'b0) begin
                n_fail++; $display("FAIL tx_abc_busy[%0d]: got %b expected 0", i, strobes[i].busy);
            end
            if (i > 0) begin
                n_tests++;
                if (strobes[i].cyc - strobes[i-1].cyc < 12) begin
                    n_fail++; $display("FAIL tx_abc_spacing[%0d]: got %0d expected >=12", i, strobes[i].cyc - strobes[i-1].cyc);
                end
            end
        end

        repeat (20) @(negedge clk_i);
        strobes.delete();
        n = $urandom_range(4, 12);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            model.push_back(b);
            io_write(12'h000, {24'h0, b});
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end
        wait_strobes(n, 600);
        repeat (30) @(negedge clk_i);
        n_tests++;
        if (strobes.size() != n) begin
            n_fail++; $display("FAIL tx_rand_count: got %0d expected %0d", strobes.size(), n);
        end
        for (int i = 0; i < strobes.size() && i < n; i++) begin
            n_tests++;
            if (strobes[i].data !== model[i]) begin
                n_fail++; $display("FAIL tx_rand_data[%0d]: got %h expected %h", i, strobes[i].data, model[i]);
            end
        end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] model[$];
        logic [7:0] b;
        logic [31:0] d;
        repeat (20) @(negedge clk_i);
        force_busy = 1'b1;
        strobes.delete();
        for (int i = 0; i < TX_DEPTH + 1; i++) begin
            b = 8'($urandom);
            model.push_back(b);
            io_write(12'h000, {24'h0, b});
        end
        io_read(12'h000, d);
        n_tests++;
        if (d !== 32'h5) begin
            n_fail++; $display("FAIL ovf_status: got %h expected 00000005", d);
        end
        io_read(12'h000, d);
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL ovf_cleared: got %h expected 00000001", d);
        end
        // write-while-full and STATUS read in the same cycle: set wins
        io_addr_i        = 12'h000;
        io_wdata_i       = 32'hEE;
        io_write_valid_i = 1'b1;
        io_read_valid_i  = 1'b1;
        @(negedge clk_i);
        io_write_valid_i = 1'b0;
        io_read_valid_i  = 1'b0;
        d = io_rdata_o;
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL ovf_setclr_read: got %h expected 00000001", d);
        end
        io_read(12'h000, d);
        n_tests++;
        if (d !== 32'h5) begin
            n_fail++; $display("FAIL ovf_set_wins: got %h expected 00000005", d);
        end
        force_busy = 1'b0;
        wait_strobes(TX_DEPTH, 600);
        repeat (40) @(negedge clk_i);
        n_tests++;
        if (strobes.size() != TX_DEPTH) begin
            n_fail++; $display("FAIL ovf_drain_count: got %0d expected %0d", strobes.size(), TX_DEPTH);
        end
        for (int i = 0; i < strobes.size() && i < TX_DEPTH; i++) begin
            n_tests++;
            if (strobes[i].data !== model[i]) begin
                n_fail++; $display("FAIL ovf_drain_data[%0d]: got %h expected %h", i, strobes[i].data, model[i]);
            end
        end
        io_read(12'h000, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL ovf_final_status: got %h expected 00000000", d);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] model[$];
        logic [7:0] b;
        logic [31:0] d;
        repeat (20) @(negedge clk_i);
        force_busy = 1'b1;
        strobes.delete();
        for (int i = 0; i < TX_DEPTH; i++) begin
            b = 8'($urandom);
            model.push_back(b);
            io_write(12'h000, {24'h0, b});
        end
        b = 8'($urandom);
        model.push_back(b);
        force_busy = 1'b0;
        io_write(12'h000, {24'h0, b});
        io_read(12'h000, d);
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL fullpp_status: got %h expected 00000001", d);
        end
        wait_strobes(TX_DEPTH + 1, 700);
        repeat (30) @(negedge clk_i);
        n_tests++;
        if (strobes.size() != TX_DEPTH + 1) begin
            n_fail++; $display("FAIL fullpp_count: got %0d expected %0d", strobes.size(), TX_DEPTH + 1);
        end
        for (int i = 0; i < strobes.size() && i < TX_DEPTH + 1; i++) begin
            n_tests++;
            if (strobes[i].data !== model[i]) begin
                n_fail++; $display("FAIL fullpp_data[%0d]: got %h expected %h", i, strobes[i].data, model[i]);
            end
        end
    endtask

    task automatic test_rx_fill();
        logic [31:0] d;
        for (int i = 0; i < RX_DEPTH; i++) begin
            n_tests++;
            if (uart_rx_ready_o !== 1'b1) begin
                n_fail++; $display("FAIL rxfill_ready[%0d]: got %b expected 1", i, uart_rx_ready_o);
            end
            uart_rx_valid_i = 1'b1;
            uart_rx_data_i  = 8'(8'h10 + i);
            @(negedge clk_i);
        end
        uart_rx_data_i = 8'h99;
        n_tests++;
        if (uart_rx_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL rxfill_full_ready: got %b expected 0", uart_rx_ready_o);
        end
        repeat (3) @(negedge clk_i);
        uart_rx_valid_i = 1'b0;
        io_read(12'h000, d);
        n_tests++;
        if (d !== 32'h0000_1002) begin
            n_fail++; $display("FAIL rxfill_status: got %h expected 00001002", d);
        end
        for (int i = 0; i < RX_DEPTH; i++) begin
            io_read(12'h008, d);
            n_tests++;
            if (d !== 32'(8'h10 + i)) begin
                n_fail++; $display("FAIL rxfill_read[%0d]: got %h expected %h", i, d, 32'(8'h10 + i));
            end
        end
        io_read(12'h008, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL rxfill_empty_read: got %h expected 00000000", d);
        end
        io_read(12'h000, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL rxfill_empty_status: got %h expected 00000000", d);
        end
        n_tests++;
        if (uart_rx_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL rxfill_ready_after: got %b expected 1", uart_rx_ready_o);
        end
    endtask

    task automatic test_rx_simultaneous();
        logic [7:0] q[$];
        logic [7:0] b, e;
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            uart_rx_valid_i = 1'b1;
            uart_rx_data_i  = b;
            @(negedge clk_i);
        end
        b = 8'($urandom);
        uart_rx_data_i  = b;
        io_addr_i       = 12'h008;
        io_read_valid_i = 1'b1;
        @(negedge clk_i);
        uart_rx_valid_i = 1'b0;
        io_read_valid_i = 1'b0;
        d = io_rdata_o;
        e = q.pop_front();
        q.push_back(b);
        n_tests++;
        if (d !== {24'h0, e}) begin
            n_fail++; $display("FAIL rxsim_read: got %h expected %h", d, {24'h0, e});
        end
        io_read(12'h000, d);
        n_tests++;
        if (d !== 32'h0000_0502) begin
            n_fail++; $display("FAIL rxsim_status: got %h expected 00000502", d);
        end
        for (int i = 0; i < 5; i++) begin
            io_read(12'h008, d);
            e = q.pop_front();
            n_tests++;
            if (d !== {24'h0, e}) begin
                n_fail++; $display("FAIL rxsim_order[%0d]: got %h expected %h", i, d, {24'h0, e});
            end
        end
    endtask

    task automatic test_rx_random();
        logic [7:0] q[$];
        logic [7:0] b;
        logic [31:0] exp_d, d;
        logic push, pop;
        io_addr_i = 12'h008;
        for (int c = 0; c < 120; c++) begin
            push = ($urandom_range(0, 99) < 65);
            pop  = ($urandom_range(0, 99) < 35);
            b    = 8'($urandom);
            n_tests++;
            if (uart_rx_ready_o !== (q.size() < RX_DEPTH)) begin
                n_fail++; $display("FAIL rxrand_ready[%0d]: got %b expected %b", c, uart_rx_ready_o, q.size() < RX_DEPTH);
            end
            exp_d = (q.size() > 0) ? {24'h0, q[0]} : 32'h0;
            uart_rx_valid_i = push;
            uart_rx_data_i  = b;
            io_read_valid_i = pop;
            @(negedge clk_i);
            d = io_rdata_o;
            n_tests++;
            if (d !== exp_d) begin
                n_fail++; $display("FAIL rxrand_rdata[%0d]: got %h expected %h", c, d, exp_d);
            end
            if (push && q.size() < RX_DEPTH) begin
                if (pop && q.size() > 0) void'(q.pop_front());
                q.push_back(b);
            end else if (pop && q.size() > 0) begin
                void'(q.pop_front());
            end
        end
        uart_rx_valid_i = 1'b0;
        io_read_valid_i = 1'b0;
        while (q.size() > 0) begin
            io_read(12'h008, d);
            b = q.pop_front();
            n_tests++;
            if (d !== {24'h0, b}) begin
                n_fail++; $display("FAIL rxrand_drain: got %h expected %h", d, {24'h0, b});
            end
        end
        io_read(12'h000, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL rxrand_final_status: got %h expected 00000000", d);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        uart_rx_valid_i = 1'b1;
        uart_rx_data_i  = 8'h77;
        @(negedge clk_i);
        uart_rx_valid_i = 1'b0;
        strobes.delete();
        io_read(12'h808, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_808: got %h expected 00000000", d);
        end
        io_read(12'h004, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_004: got %h expected 00000000", d);
        end
`ifndef IO_UART_LOOPBACK_EN
        io_read(12'h010, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_010: got %h expected 00000000", d);
        end
        io_write(12'h010, 32'h33);
`endif
        io_write(12'h800, 32'h11);
        io_write(12'h004, 32'h22);
        repeat (30) @(negedge clk_i);
        n_tests++;
        if (strobes.size() != 0) begin
            n_fail++; $display("FAIL unmapped_write_strobe: got %0d expected 0", strobes.size());
        end
        io_read(12'h000, d);
        n_tests++;
        if (d !== 32'h0000_0102) begin
            n_fail++; $display("FAIL unmapped_status: got %h expected 00000102", d);
        end
        io_read(12'h008, d);
        n_tests++;
        if (d !== 32'h77) begin
            n_fail++; $display("FAIL unmapped_rx_intact: got %h expected 00000077", d);
        end
    endtask

`ifdef IO_UART_LOOPBACK_EN
    task automatic test_loopback();
        logic [31:0] d;
        repeat (20) @(negedge clk_i);
        strobes.delete();
        io_write(12'h010, 32'h1);
        io_read(12'h010, d);
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL lb_ctrl_read: got %h expected 00000001", d);
        end
        n_tests++;
        if (uart_rx_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL lb_rx_ready: got %b expected 0", uart_rx_ready_o);
        end
        io_write(12'h000, 32'h5A);
        wait_strobes(1, 50);
        n_tests++;
        if (strobes.size() != 1) begin
            n_fail++; $display("FAIL lb_strobe_count: got %0d expected 1", strobes.size());
        end else begin
            n_tests++;
            if (strobes[0].data !== 8'h5A) begin
                n_fail++; $display("FAIL lb_strobe_data: got %h expected 5a", strobes[0].data);
            end
        end
        repeat (3) @(negedge clk_i);
        io_read(12'h000, d);
        n_tests++;
        if (d !== 32'h0000_0102) begin
            n_fail++; $display("FAIL lb_status: got %h expected 00000102", d);
        end
        io_read(12'h008, d);
        n_tests++;
        if (d !== 32'h5A) begin
            n_fail++; $display("FAIL lb_rx_read: got %h expected 0000005a", d);
        end
        io_write(12'h010, 32'h0);
        io_read(12'h010, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL lb_ctrl_off: got %h expected 00000000", d);
        end
        n_tests++;
        if (uart_rx_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL lb_rx_ready_off: got %b expected 1", uart_rx_ready_o);
        end
    endtask
`endif

    initial begin
        rst_i            = 1'b1;
        io_read_valid_i  = 1'b0;
        io_write_valid_i = 1'b0;
        io_addr_i        = 12'h000;
        io_wdata_i       = 32'h0;
        uart_rx_data_i   = 8'h00;
        uart_rx_valid_i  = 1'b0;
        @(negedge clk_i);

        test_reset();
        test_reset_mid_transfer();
        test_tx_order();
        test_tx_overflow();
        test_full_push_pop();
        test_rx_fill();
        test_rx_simultaneous();
        test_rx_random();
        test_unmapped();
`ifdef IO_UART_LOOPBACK_EN
        test_loopback();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/io_uart_fifo.md
Name: io_uart_fifo

Overview:
- Memory-mapped UART buffering stage between the Memory_Ctrl IO port and the uart core.
- Holds CPU trace/console TX bytes in a FIFO and drains them to the uart AXI-stream input, honouring tx_busy.
- Buffers received bytes in an RX FIFO so the CPU can read bursts without losing data.
- Replaces the single-register TRACE_REG/UART_DATA logic in the system-control block.

Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of two, 2..256.
- RX_DEPTH, 16, RX FIFO entries; power of two, 2..256.

Ports:
- clk_i  in  1  system clock (clk_sys)
- rst_i  in  1  asynchronous reset, active-high
- io_read_valid_i  in  1  one-cycle IO read strobe
- io_write_valid_i  in  1  one-cycle IO write strobe
- io_addr_i  in  12  IO byte address (low bits)
- io_wdata_i  in  32  IO write data
- io_rdata_o  out  32  IO read data, registered
- uart_tx_data_o  out  8  byte to uart s_axis_tdata
- uart_tx_strobe_o  out  1  one-cycle s_axis_tvalid pulse
- uart_tx_busy_i  in  1  uart tx_busy
- uart_rx_data_i  in  8  uart m_axis_tdata
- uart_rx_valid_i  in  1  uart m_axis_tvalid
- uart_rx_ready_o  out  1  uart m_axis_tready

Behaviour:
- Reset: asynchronous, active-high. All outputs 0; FIFOs empty; FSM in IDLE; sticky flags 0.
- Register map (io_addr_i[11:0]):
  - 0x000 write: push io_wdata_i[7:0] to TX FIFO.
  - 0x000 read: STATUS = {16'h0, rx_count[7:0], 5'h0, tx_ovf, rx_nonempty, tx_full}.
  - 0x008 read: returns {24'h0, RX head} and pops. If RX is empty, returns 0 and does not pop.
  - Other addresses: reads return 0; writes are ignored.
- io_rdata_o timing: updated on the clock edge after io_addr_i is presented, every cycle regardless of the read strobe. The pop happens only on io_read_valid_i.
- TX overflow: a push while full drops the byte and sets tx_ovf. tx_ovf is cleared on the cycle after a STATUS read with io_read_valid_i. A simultaneous set and clear leaves tx_ovf = 1.
- TX drain FSM:
  - IDLE: if TX not empty and !uart_tx_busy_i, then pop, drive uart_tx_data_o = head and uart_tx_strobe_o = 1 for exactly one cycle, and go to HOLD.
  - HOLD: one cycle, covering busy-rise latency; go to WAIT.
  - WAIT: stay while uart_tx_busy_i = 1; go to IDLE when it is 0.
  - Minimum spacing between strobes: 3 cycles.
  - uart_tx_data_o holds its value until the next strobe.
- RX path: uart_rx_ready_o = !rx_full, combinational from registered count. A byte is pushed when uart_rx_valid_i && uart_rx_ready_o. When full, the uart holds its data (its own overrun flag applies).
- Simultaneous push and pop on either FIFO:
  - Non-empty FIFO: both occur; count is unchanged.
  - Empty FIFO: the pop is ignored and the push occurs.
  - Full TX FIFO: a CPU push in the same cycle as a drain pop is accepted.
- Counts are width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH. rx_count in STATUS saturates at 255.
- Reset mid-transfer: any FIFO contents are discarded, and a strobe in progress is truncated to 0 immediately.

Optional Feature:
- Macro: IO_UART_LOOPBACK_EN.
- When defined:
  - Register 0x010 bit0 is LOOPBACK (R/W, reset 0).
  - With LOOPBACK = 1, each byte the FSM strobes is pushed into the RX FIFO in the same cycle (dropped if RX is full), and uart_rx_ready_o is forced to 0.
  - The uart still receives the strobe.
- When undefined: 0x010 behaves as an unmapped address and there is no loopback logic.

Test Plan:
- Reset, then read 0x000 -> io_rdata_o = 0x00000000 the next cycle. uart_tx_strobe_o and uart_rx_ready_o are 0 during reset, and uart_rx_ready_o = 1 after reset.
- Write 0x41, 0x42, 0x43 to 0x000 back-to-back, with a uart model holding busy for 10 cycles per byte -> three strobes carrying 0x41, 0x42, 0x43 in order, each while busy = 0, spaced by 12 or more cycles.
- Busy held high, 17 writes with TX_DEPTH = 16 -> STATUS = 0x00000005 (tx_full, tx_ovf). The 17th byte is never strobed. A second STATUS read returns bit2 = 0.
- Inject RX bytes 0x10..0x1F (16 bytes) -> STATUS rx_count = 16 and uart_rx_ready_o = 0. Sixteen reads of 0x008 return 0x10..0x1F in order. A 17th read returns 0 and rx_count stays 0.
- Same-cycle RX push and 0x008 pop with count 5 -> count stays 5 and FIFO order is preserved.
- With IO_UART_LOOPBACK_EN: write 0x010 = 1, then write 0x5A to 0x000 -> after the strobe, STATUS bit1 = 1 and a 0x008 read returns 0x0000005A.
